// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default sizes and pointer code conversions.
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;

  // Conversions work on a wide container; callers zero-extend their pointer
  // and truncate the result, so one function serves every pointer width.
  localparam int PTR_MAXW = 32;

  function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down; zero upper bits leave the result unaffected.
  function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] winner
);

  logic [IDXW-1:0] last_q;
  logic [IDXW-1:0] last_d;
  logic [IDXW:0]   sum;
  logic [IDXW-1:0] idx;
  logic            found;

  // Pick the first set request at or after last+1, wrapping modulo NREQ.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      sum = {1'b0, last_q} + (IDXW+1)'(off);
      if (sum >= (IDXW+1)'(NREQ)) begin
        sum = sum - (IDXW+1)'(NREQ);
      end
      idx = sum[IDXW-1:0];
      if (enable && !found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        winner      = idx;
      end
    end
  end

  // Priority moves to the winner only on a cycle that actually writes.
  always_comb begin
    last_d = last_q;
    if (advance) begin
      last_d = winner;
    end
  end

  // Priority register; reset makes requester 0 first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDXW'(NREQ-1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: arbitrates requesters onto the single
// write port and owns the binary/Gray write pointer, full flag and occupancy.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = FIFO_DSIZE,
  parameter int ASIZE = FIFO_ASIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic [ASIZE:0]        wq2_rptr,
  output logic                  winc,
  output logic [ASIZE-1:0]      waddr,
  output logic [DSIZE-1:0]      wdata,
  output logic [ASIZE:0]        wptr,
  output logic                  wfull,
  output logic [ASIZE:0]        wcount
);

  localparam int PW   = ASIZE + 1;
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   wbin_q,   wbin_d;
  logic [PW-1:0]   wptr_q,   wptr_d;
  logic            wfull_q,  wfull_d;
  logic [PW-1:0]   wcount_q, wcount_d;
  logic [IDXW-1:0] winner;
  logic            arb_en;

  // No grant while full, and none while reset is held.
  assign arb_en = !wfull_q && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .enable  (arb_en),
    .advance (winc),
    .gnt     (gnt),
    .winner  (winner)
  );

  assign winc  = |gnt;
  assign waddr = wbin_q[ASIZE-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;
  assign wcount = wcount_q;

  // Route the granted requester's slice to the memory; zero when idle.
  always_comb begin
    wdata = '0;
    if (winc) begin
      wdata = req_data[winner*DSIZE +: DSIZE];
    end
  end

  // Next pointer, full compare against the synchronized read pointer, and
  // occupancy; full means MSB and next bit inverted, remaining Gray bits equal.
  always_comb begin
    wbin_d   = wbin_q + PW'(winc);
    wptr_d   = PW'(bin2gray(PTR_MAXW'(wbin_d)));
    wfull_d  = (wptr_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
    wcount_d = wbin_d - PW'(gray2bin(PTR_MAXW'(wq2_rptr)));
  end

  // Pointer, full and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wcount_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wcount_q <= wcount_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed table, hand sequences, and random traffic
// against an occupancy/round-robin reference model.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [4:0]  wq2_rptr;
  logic        winc;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [4:0]  wptr;
  logic        wfull;
  logic [4:0]  wcount;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .ASIZE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .wq2_rptr (wq2_rptr),
    .winc     (winc),
    .waddr    (waddr),
    .wdata    (wdata),
    .wptr     (wptr),
    .wfull    (wfull),
    .wcount   (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: write and read counts as integers, last winner index.
  int         m_wr, m_rd, m_last, m_cnt;
  bit         m_full;
  logic [3:0] e_gnt;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          rb;
    logic [3:0]  gnt;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic [4:0]  wptr;
    logic [4:0]  wcount;
    logic        wfull;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  // Winner = set request at the smallest circular distance past the last winner.
  function automatic logic [3:0] model_gnt(input logic [3:0] r);
    int best, bestd, d;
    logic [3:0] g;
    g = '0;
    if (m_full || r == 4'b0) return g;
    best = -1;
    bestd = 4;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        d = (i - m_last - 1 + 8) % 4;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    g[best] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_last = 3; m_cnt = 0; m_full = 0;
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic drive(input logic [3:0] r, input logic [31:0] d, input int rb);
    req      = r;
    req_data = d;
    m_rd     = rb & 31;
    wq2_rptr = gray5(m_rd);
    #1;
    e_gnt = model_gnt(r);
  endtask

  // Clock edge, then model bookkeeping for the registered outputs.
  task automatic tick();
    int occ;
    @(posedge clk);
    if (e_gnt != 4'b0) begin
      m_wr = (m_wr + 1) & 31;
      for (int i = 0; i < 4; i++) if (e_gnt[i]) m_last = i;
    end
    occ    = (m_wr - m_rd) & 31;
    m_full = (occ == 16);
    m_cnt  = occ;
    #1;
  endtask

  task automatic chk_comb_model();
    int w;
    chk("m_gnt", gnt, e_gnt);
    chk("m_winc", winc, |e_gnt);
    chk("m_waddr", waddr, m_wr & 15);
    if (e_gnt != 4'b0) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (e_gnt[i]) w = i;
      chk("m_wdata", wdata, (req_data >> (8*w)) & 32'hFF);
    end
  endtask

  task automatic chk_reg_model();
    chk("m_wptr", wptr, gray5(m_wr));
    chk("m_wfull", wfull, m_full);
    chk("m_wcount", wcount, m_cnt);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'b1111;
    req_data = 32'h0;
    wq2_rptr = 5'b0;
    #1;
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_winc", winc, 1'b0);
    chk("rst_wptr", wptr, 5'b0);
    chk("rst_wfull", wfull, 1'b0);
    chk("rst_wcount", wcount, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] prev;
    int rb;
    logic [3:0] r;

    tbl[0] = '{4'b1111, 32'h44332211, 0, 4'b0001, 4'd0, 8'h11, 5'b00001, 5'd1, 1'b0};
    tbl[1] = '{4'b0010, 32'h0000A500, 0, 4'b0010, 4'd1, 8'hA5, 5'b00011, 5'd2, 1'b0};
    tbl[2] = '{4'b1111, 32'hDDCCBBAA, 0, 4'b0100, 4'd2, 8'hCC, 5'b00010, 5'd3, 1'b0};
    tbl[3] = '{4'b1001, 32'h77000066, 0, 4'b1000, 4'd3, 8'h77, 5'b00110, 5'd4, 1'b0};
    tbl[4] = '{4'b0000, 32'h12345678, 0, 4'b0000, 4'd4, 8'h00, 5'b00110, 5'd4, 1'b0};
    tbl[5] = '{4'b0110, 32'h00EE9900, 2, 4'b0010, 4'd4, 8'h99, 5'b00111, 5'd3, 1'b0};
    tbl[6] = '{4'b0001, 32'h000000F0, 2, 4'b0001, 4'd5, 8'hF0, 5'b00101, 5'd4, 1'b0};
    tbl[7] = '{4'b0001, 32'h0000005A, 3, 4'b0001, 4'd6, 8'h5A, 5'b00100, 5'd4, 1'b0};

    rst = 1'b1;
    req = '0;
    req_data = '0;
    wq2_rptr = '0;
    model_reset();
    e_gnt = '0;
    #2;

    // Directed table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].req, tbl[i].data, tbl[i].rb);
      chk("t_gnt", gnt, tbl[i].gnt);
      chk("t_winc", winc, |tbl[i].gnt);
      chk("t_waddr", waddr, tbl[i].waddr);
      if (tbl[i].gnt != 4'b0) chk("t_wdata", wdata, tbl[i].wdata);
      tick();
      chk("t_wptr", wptr, tbl[i].wptr);
      chk("t_wcount", wcount, tbl[i].wcount);
      chk("t_wfull", wfull, tbl[i].wfull);
    end

    // Fairness up to full, then drain one and refill
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(4'b1111, 32'h0, 0);
      chk("fair_gnt", gnt, 4'b0001 << (k % 4));
      tick();
      chk("fair_wfull", wfull, (k == 15));
      if (k == 15) chk("fair_wcount", wcount, 5'd16);
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'b1111, 32'h0, 0);
      chk("full_gnt", gnt, 4'b0);
      chk("full_winc", winc, 1'b0);
      tick();
      chk("full_wcount", wcount, 5'd16);
    end
    drive(4'b1111, 32'h0, 1);
    chk("drain_gnt0", gnt, 4'b0);
    tick();
    chk("drain_wfull", wfull, 1'b0);
    chk("drain_wcount", wcount, 5'd15);
    drive(4'b1111, 32'h0, 1);
    chk("drain_gnt1", gnt, 4'b0001);
    tick();
    chk("refill_wfull", wfull, 1'b1);
    chk("refill_wcount", wcount, 5'd16);
    drive(4'b1111, 32'h0, 1);
    chk("refill_gnt", gnt, 4'b0);
    tick();

    // Pointer wrap with the read pointer one write behind
    do_reset();
    for (int k = 0; k < 40; k++) begin
      drive(4'b0100, 32'h00C30000 + k, (k > 0) ? k - 1 : 0);
      chk("wrap_gnt", gnt, 4'b0100);
      chk("wrap_waddr", waddr, k % 16);
      prev = wptr;
      tick();
      chk("wrap_onebit", $countones(wptr ^ prev), 1);
      chk("wrap_wfull", wfull, 1'b0);
      if (k == 15) chk("wrap_gray16", wptr, 5'b11000);
      chk_reg_model();
    end

    // Reset while a grant is in flight
    drive(4'b0100, 32'h00550000, 39);
    chk("mb_gnt", gnt, 4'b0100);
    rst = 1'b1;
    #1;
    chk("mb_gnt_rst", gnt, 4'b0);
    chk("mb_winc_rst", winc, 1'b0);
    chk("mb_wptr_rst", wptr, 5'b0);
    chk("mb_wfull_rst", wfull, 1'b0);
    chk("mb_wcount_rst", wcount, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(4'b1111, 32'h0, 0);
    chk("mb_first_gnt", gnt, 4'b0001);
    tick();
    chk("mb_wptr", wptr, 5'b00001);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0;
      rb = m_rd;
      if (((m_wr - m_rd) & 31) != 0 && $urandom_range(0, 2) == 0) rb = m_rd + 1;
      drive(r, $urandom, rb);
      chk_comb_model();
      tick();
      chk_reg_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the async FIFO. Shares the single FIFO write port among NREQ requesters using round-robin arbitration.
- Owns the write pointer in both binary and Gray form, the full flag and an occupancy estimate.
- Runs entirely in the write clock domain. Consumes the read pointer only after it has crossed into this domain through the 2-FF synchronizer (wq2_rptr).

Parameters:
- NREQ, 4, number of requesters (>=2)
- DSIZE, 8, data width in bits
- ASIZE, 4, address bits; FIFO depth = 2**ASIZE

Ports:
- clk  input  1  write-domain clock
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request; held until granted
- req_data  input  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE]
- gnt  output  NREQ  one-hot grant, combinational; data accepted at the edge where gnt[i]=1
- wq2_rptr  input  ASIZE+1  Gray read pointer, already synchronized into clk domain
- winc  output  1  memory write enable, combinational
- waddr  output  ASIZE  memory write address, equal to wbin[ASIZE-1:0]
- wdata  output  DSIZE  muxed data of the granted requester
- wptr  output  ASIZE+1  registered Gray write pointer, sent to the read-side synchronizer
- wfull  output  1  registered full flag
- wcount  output  ASIZE+1  registered occupancy estimate, 0..2**ASIZE

Behaviour:
- Reset: rst high asynchronously clears the following:
  - wbin=0, wptr=0, wfull=0, wcount=0
  - round-robin pointer last=NREQ-1, so req[0] has top priority first
  - gnt=0 and winc=0 are forced while rst=1
- Arbitration (combinational, per cycle):
  - When wfull=1 or req==0: gnt=0, winc=0.
  - Otherwise the search starts at index (last+1) mod NREQ and wraps; the first set req wins.
  - gnt has exactly one bit set; winc=1; wdata=req_data slice of the winner.
- Priority update: last <= winner index on every clock edge with winc=1. Otherwise last holds.
- Pointer update on every edge:
  - wbin_next = wbin + winc, modulo 2**(ASIZE+1)
  - wgray_next = wbin_next ^ (wbin_next>>1)
  - wbin <= wbin_next; wptr <= wgray_next
- Full, registered on every edge:
  - wfull <= (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]})
  - Full therefore asserts on the edge that performs the 2**ASIZE-th unread write. No further grant occurs while wfull=1.
- Occupancy, registered on every edge:
  - wcount <= wbin_next - gray2bin(wq2_rptr), modulo 2**(ASIZE+1)
  - The value is pessimistic because of synchronizer lag. It is never less than the true occupancy.
- Latency:
  - The grant is seen the same cycle as req.
  - wptr, wfull and wcount reflect a write one edge later.
  - A change in wq2_rptr affects wfull and wcount one edge later.
- Boundary conditions:
  - Pointer wrap: waddr wraps 2**ASIZE-1 -> 0 and the MSB of wbin toggles. Gray wptr changes exactly one bit per write, including at the wrap.
  - Read pointer advances while full: wfull deasserts on the next edge. Arbitration resumes that cycle with the priority pointer unchanged.
  - Single requester: that requester may be granted on consecutive cycles.
  - A request dropped before grant is not recorded.
  - Reset mid-burst: an in-flight grant is abandoned with no write, and the requester must re-request.
  - wq2_rptr that is not a valid Gray step is not checked.

Decomposition:
- Package fifo_pkg holds:
  - FIFO_DSIZE and FIFO_ASIZE defaults
  - function bin2gray(ASIZE+1 bits)
  - function gray2bin(ASIZE+1 bits), using an XOR prefix from the MSB
- Sub-module rr_arbiter #(NREQ):
  - inputs: req, enable (!wfull), last, advance
  - outputs: one-hot gnt, winner index
  - contains the priority register
- fifo_wr_arbiter contains the pointer, full and count registers plus the data mux.

Test Plan:
Parameters for all scenarios: NREQ=4, DSIZE=8, ASIZE=4.
- Reset: rst=1 with req=4'b1111 -> gnt=0, winc=0, wptr=0, wfull=0, wcount=0. Release rst -> the first grant is gnt=4'b0001.
- Single write: req=4'b0010, req_data[15:8]=8'hA5, wq2_rptr=0 -> gnt=4'b0010, winc=1, waddr=0, wdata=8'hA5. Next edge: wptr=5'b00001, wcount=1.
- Fairness: req=4'b1111 held, wq2_rptr=0 -> gnt sequence 0001,0010,0100,1000,0001,... After the 16th write: wfull=1, wcount=16, gnt=0 held.
- Drain while full: from full, set wq2_rptr=5'b00001 (Gray 1) -> next edge wfull=0, then one grant, then wfull=1 again with wcount=16.
- Wrap: 40 writes with wq2_rptr tracking wptr one write behind -> waddr wraps 15->0, wptr follows the Gray sequence through 5'b11000 (bin 16) without multi-bit changes, wfull never asserts.
- Reset mid-burst: assert rst during the grant to req[2] -> gnt, winc, wptr and wfull clear immediately. After release, req=4'b1111 grants req[0] first.
